// File: rtl/btn_step_conditioner.sv
// rtl/btn_step_conditioner.sv - two-button conditioner: sync, debounce, edge detect, step hold/repeat FSM, direction toggle
// Bit 0 of each per-button vector is the step button, bit 1 the direction button.
module btn_step_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_STEP,
    input  logic BTN_DIR,
    output logic STEP_PULSE,
    output logic DIR,
    output logic STEP_HELD
);

    localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > HOLD_CYCLES)
                              ? ((DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES)
                              : ((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [1:0]         raw_btn;
    logic [1:0]         sync1_q;
    logic [1:0]         sync2_q;
    logic [1:0]         stable_q;
    logic [1:0]         stable_d;
    logic [1:0]         stable_prev_q;
    logic [1:0]         rise_q;
    logic [1:0][CW-1:0] db_cnt_q;
    logic [1:0][CW-1:0] db_cnt_d;

    state_t             state_q;
    state_t             state_d;
    logic [CW-1:0]      hold_cnt_q;
    logic [CW-1:0]      hold_cnt_d;
    logic               pulse_q;
    logic               pulse_d;
    logic               held_q;
    logic               held_d;
    logic               dir_q;
    logic               dir_d;

    assign raw_btn = {BTN_DIR, BTN_STEP};

    always_comb begin
        db_cnt_d = '0;
        stable_d = stable_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Rising edges are registered so the step and direction paths share the same latency.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            rise_q        <= '0;
            db_cnt_q      <= '0;
        end else begin
            sync1_q       <= raw_btn;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            rise_q        <= stable_q & ~stable_prev_q;
            db_cnt_q      <= db_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        pulse_d    = 1'b0;
        if (!stable_q[0]) begin
            // A release overrides any terminal count reached on the same cycle.
            state_d    = IDLE;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise_q[0]) begin
                        state_d    = HOLD;
                        pulse_d    = 1'b1;
                        hold_cnt_d = '0;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = REPEAT;
                        pulse_d    = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (hold_cnt_q == REPEAT_LAST) begin
                        pulse_d    = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end
            endcase
        end
        held_d = (state_d == REPEAT);
        dir_d  = dir_q ^ rise_q[1];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            pulse_q    <= 1'b0;
            held_q     <= 1'b0;
            dir_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            pulse_q    <= pulse_d;
            held_q     <= held_d;
            dir_q      <= dir_d;
        end
    end

    assign STEP_PULSE = pulse_q;
    assign STEP_HELD  = held_q;
    assign DIR        = dir_q;

endmodule

// File: tb/tb_btn_step_conditioner.sv
// tb/tb_btn_step_conditioner.sv - scoreboard bench for btn_step_conditioner
module tb_btn_step_conditioner;

    localparam int DB  = 4;
    localparam int HC  = 20;
    localparam int RC  = 8;
    localparam int LAT = DB + 3;
    localparam int REL = DB + 2;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic BTN_STEP = 1'b0;
    logic BTN_DIR = 1'b0;
    logic STEP_PULSE;
    logic DIR;
    logic STEP_HELD;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;
    logic exp_dir = 1'b1;

    int pulse_exp_q[$];
    int held_exp_q[$];
    int dir_exp_q[$];
    int dir_val_q[$];

    logic pulse_prev = 1'b0;
    logic held_prev = 1'b0;
    logic dir_prev = 1'b1;

    btn_step_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES(HC),
        .REPEAT_CYCLES(RC)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .BTN_STEP(BTN_STEP),
        .BTN_DIR(BTN_DIR),
        .STEP_PULSE(STEP_PULSE),
        .DIR(DIR),
        .STEP_HELD(STEP_HELD)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_n <= edge_n + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Expected step activity for a clean press sampled high on edges a .. b-1.
    task automatic expect_press(input int a, input int b);
        int t;
        int rel;
        if (b - a < DB) return;
        rel = b + REL;
        t = a + LAT;
        pulse_exp_q.push_back(t);
        t = t + HC;
        if (t < rel) begin
            pulse_exp_q.push_back(t);
            held_exp_q.push_back(t);
            while (t + RC < rel) begin
                t = t + RC;
                pulse_exp_q.push_back(t);
            end
            held_exp_q.push_back(rel);
        end
    endtask

    task automatic expect_dir(input int a, input int n);
        if (n >= DB) begin
            exp_dir = ~exp_dir;
            dir_exp_q.push_back(a + LAT);
            dir_val_q.push_back(int'(exp_dir));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press_step(input int n);
        expect_press(edge_n + 1, edge_n + 1 + n);
        BTN_STEP = 1'b1;
        idle(n);
        BTN_STEP = 1'b0;
    endtask

    task automatic press_dir(input int n);
        expect_dir(edge_n + 1, n);
        BTN_DIR = 1'b1;
        idle(n);
        BTN_DIR = 1'b0;
    endtask

    task automatic press_both(input int n);
        expect_press(edge_n + 1, edge_n + 1 + n);
        expect_dir(edge_n + 1, n);
        BTN_STEP = 1'b1;
        BTN_DIR = 1'b1;
        idle(n);
        BTN_STEP = 1'b0;
        BTN_DIR = 1'b0;
    endtask

    task automatic async_reset(input string tag, input int n);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk({tag, "_pulse"}, STEP_PULSE, 0);
        chk({tag, "_held"}, STEP_HELD, 0);
        chk({tag, "_dir"}, DIR, 1);
        pulse_exp_q.delete();
        held_exp_q.delete();
        dir_exp_q.delete();
        dir_val_q.delete();
        exp_dir = 1'b1;
        idle(n);
        RST = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            if (STEP_PULSE === 1'b1) begin
                chk("pulse_gap", pulse_prev, 0);
                if (pulse_exp_q.size() == 0) chk("pulse_unexpected", edge_n, -1);
                else chk("pulse_edge", edge_n, pulse_exp_q.pop_front());
            end
            if (STEP_HELD !== held_prev) begin
                if (held_exp_q.size() == 0) chk("held_unexpected", edge_n, -1);
                else chk("held_edge", edge_n, held_exp_q.pop_front());
            end
            if (DIR !== dir_prev) begin
                if (dir_exp_q.size() == 0) chk("dir_unexpected", edge_n, -1);
                else begin
                    chk("dir_edge", edge_n, dir_exp_q.pop_front());
                    chk("dir_val", DIR, dir_val_q.pop_front());
                end
            end
        end
        pulse_prev <= STEP_PULSE;
        held_prev <= STEP_HELD;
        dir_prev <= DIR;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        int w;
        #1 RST = 1'b1;
        idle(3);
        RST = 1'b0;
        chk("por_pulse", STEP_PULSE, 0);
        chk("por_held", STEP_HELD, 0);
        chk("por_dir", DIR, 1);
        idle(5);

        async_reset("rst1", 2);
        idle(20);
        chk("idle_dir", DIR, 1);
        chk("idle_held", STEP_HELD, 0);

        press_step(15);
        idle(15);

        BTN_STEP = 1'b1; idle(3);
        BTN_STEP = 1'b0; idle(3);
        BTN_STEP = 1'b1; idle(3);
        BTN_STEP = 1'b0; idle(3);
        press_step(10);
        idle(15);

        press_step(80);
        idle(15);
        chk("after_repeat_held", STEP_HELD, 0);

        press_dir(12);
        idle(15);
        press_dir(12);
        idle(15);
        press_dir(40);
        idle(15);
        chk("dir_after_hold", DIR, exp_dir);

        press_both(12);
        idle(15);

        a = edge_n + 1;
        expect_press(a, a + 1000);
        BTN_STEP = 1'b1;
        w = 0;
        while (STEP_HELD !== 1'b1 && w < 60) begin
            @(negedge CLK);
            w++;
        end
        chk("held_reached", STEP_HELD, 1);
        idle(3);
        async_reset("rst2", 2);
        expect_press(edge_n + 1, edge_n + 1 + 40);
        idle(40);
        BTN_STEP = 1'b0;
        idle(20);

        chk("pulse_q_empty", pulse_exp_q.size(), 0);
        chk("held_q_empty", held_exp_q.size(), 0);
        chk("dir_q_empty", dir_exp_q.size(), 0);
        chk("final_dir", DIR, exp_dir);
        chk("final_held", STEP_HELD, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_step_conditioner.md
Name: btn_step_conditioner

Overview:
- Upstream stage of the parameterisable up/down counter.
- Turns two raw, bouncing push-buttons into clean control signals for it:
  - a one-cycle step pulse, with auto-repeat while the button is held, wired to the counter's ENABLE;
  - a direction level that toggles on each press, wired to the counter's UP_DOWN.
- Includes input synchronisation, debouncing, edge detection and a hold/repeat state machine.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz).
- HOLD_CYCLES, 25000000: cycles the step button must stay pressed, after the first pulse, before auto-repeat starts.
- REPEAT_CYCLES, 5000000: period in cycles between auto-repeat pulses.
- CW, $clog2(max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)+1): internal counter width (derived, not overridden).

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST  input  1  asynchronous, active-high reset.
- BTN_STEP  input  1  raw step button, asynchronous, 1 = pressed.
- BTN_DIR  input  1  raw direction button, asynchronous, 1 = pressed.
- STEP_PULSE  output  1  one-cycle step strobe to the counter's ENABLE.
- DIR  output  1  count direction to the counter's UP_DOWN; 1 = up, 0 = down.
- STEP_HELD  output  1  high while auto-repeat is active.

Behaviour:
- Reset (RST=1, asynchronous):
  - synchroniser flops, debounced levels, all counters and the FSM clear to 0/IDLE;
  - STEP_PULSE=0, STEP_HELD=0, DIR=1;
  - reset mid-press discards all progress; the button must be re-qualified after release of RST.
- All outputs are registered. Nothing combinational runs from raw inputs to outputs.
- Synchroniser: two flops per button. The output of the second flop is the synchronised level.
- Debouncer (one per button):
  - holds a stable level and a counter;
  - counter clears whenever the synchronised level equals the stable level;
  - otherwise the counter increments;
  - when the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the stable level takes the synchronised value and the counter clears;
  - any glitch shorter than DEBOUNCE_CYCLES cycles leaves the stable level unchanged.
- Edge detect: a rising edge is the stable level at 1 while its previous-cycle copy is 0. It lasts exactly one cycle.
- Press latency: STEP_PULSE asserts exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples BTN_STEP=1, provided the input stays clean throughout.
- Step FSM (driven by the debounced step level S), states IDLE, HOLD, REPEAT:
  - IDLE: on rising edge of S, go to HOLD, assert STEP_PULSE for 1 cycle, clear the hold counter.
  - HOLD:
    - counter increments each cycle;
    - when counter == HOLD_CYCLES-1: go to REPEAT, assert STEP_PULSE, clear counter.
  - REPEAT:
    - STEP_HELD=1;
    - counter increments;
    - when counter == REPEAT_CYCLES-1: assert STEP_PULSE, clear counter, stay in REPEAT.
  - Any state with S=0: go to IDLE next cycle, counter cleared, STEP_HELD=0, no pulse.
  - Release and terminal count in the same cycle: release wins, no pulse.
- Pulse spacing: STEP_PULSE is never high on two consecutive cycles, so HOLD_CYCLES≥2 and REPEAT_CYCLES≥2 are required.
- DIR:
  - toggles on the edge following a debounced rising edge of BTN_DIR;
  - BTN_DIR release has no effect;
  - holding BTN_DIR does not repeat.
- Simultaneous events:
  - a DIR toggle and STEP_PULSE may occur on the same edge; both take effect;
  - the counter sees the new DIR in the same cycle as the pulse.
- The two buttons are fully independent; pressing both together produces exactly one step and one toggle.

Test Plan (override DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8):
1. Reset then idle: assert RST mid-simulation, asynchronously off-edge -> STEP_PULSE=0, STEP_HELD=0 and DIR=1 immediately; all stay constant with buttons at 0.
2. Clean step press: BTN_STEP=1 for 15 cycles, then 0 -> exactly one STEP_PULSE, 7 edges after the first sampled 1; STEP_HELD stays 0.
3. Bounce rejection: BTN_STEP toggles 1,0,1,0 each lasting 3 cycles, then holds 1 for 10 cycles -> no pulse during the bounce; exactly one pulse 7 edges after the final rise.
4. Auto-repeat: BTN_STEP held 80 cycles ->
   - first pulse at +7;
   - second pulse 20 cycles later, with STEP_HELD rising on the same edge;
   - further pulses every 8 cycles;
   - release drops STEP_HELD 6 edges after BTN_STEP falls (2 sync + 4 debounce), with no extra pulse.
5. Direction toggle: two clean BTN_DIR presses -> DIR goes 1→0→1, each change 7 edges after its press; a 40-cycle hold gives a single toggle.
6. Reset mid-repeat: RST pulsed while STEP_HELD=1 and the button still pressed -> outputs return to reset values at once; after RST falls, one pulse 7 edges later, then normal hold timing restarts.
